// File: rtl/ifu_fetch_stage.sv
// ----------------------------------------------------------------------------
// ifu_fetch_stage
//
// Single-outstanding instruction fetch stage. It owns the PC and issues one
// request at a time on a valid/ready instruction-memory port. It captures the
// returned word into an instruction register and presents that word to decode
// with a valid/ready handshake.
//
// A redirect from execute is accepted in every state and always takes
// priority. A request already sent for the old path is marked stale with the
// kill flag, and its response is dropped when it arrives.
//
// Ports
//   clk              core clock, all state changes on the rising edge
//   rst              synchronous active-high reset
//   imem_req_valid   fetch request valid (from state only, gated by rst)
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    fetch address (current PC)
//   imem_rsp_valid   response word valid (never back-pressured)
//   imem_rsp_data    returned instruction word
//   inst_valid       instruction register holds a word for decode
//   inst_ready       decode consumes the word this cycle
//   inst             instruction register
//   inst_pc          PC of inst
//   opcode           inst[6:0], consumed by the immediate-type decoder
//   redirect_valid   control-flow redirect from execute
//   redirect_pc      redirect target, low two bits cleared on load
// ----------------------------------------------------------------------------
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // addi x0, x0, 0 : the value the instruction register holds out of reset
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic        kill_r;

    // Redirect targets are word aligned; any stray low bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        align_pc = {target[31:2], 2'b00};
    endfunction

    // Sequential PC; the 32-bit add wraps naturally at the top of memory.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] cur);
        next_seq_pc = cur + 32'd4;
    endfunction

    // Fetch state machine: PC, kill flag and instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_REQ;
            pc_r      <= RESET_PC;
            kill_r    <= 1'b0;
            inst_r    <= NOP_INST;
            inst_pc_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_r <= S_WAIT;
                        if (redirect_valid) begin
                            // The request has already left with the old
                            // address, so its response must be thrown away.
                            pc_r   <= align_pc(redirect_pc);
                            kill_r <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        // Nothing issued yet: just retarget the request.
                        pc_r <= align_pc(redirect_pc);
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_r || redirect_valid) begin
                            // Stale or wrong-path word: drop it and refetch.
                            kill_r  <= 1'b0;
                            state_r <= S_REQ;
                            if (redirect_valid) begin
                                pc_r <= align_pc(redirect_pc);
                            end
                        end else begin
                            inst_r    <= imem_rsp_data;
                            inst_pc_r <= pc_r;
                            state_r   <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Response still pending for the old path.
                        pc_r   <= align_pc(redirect_pc);
                        kill_r <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        // Redirect beats a same-cycle decode handshake.
                        pc_r    <= align_pc(redirect_pc);
                        state_r <= S_REQ;
                    end else if (inst_ready) begin
                        pc_r    <= next_seq_pc(pc_r);
                        state_r <= S_REQ;
                    end
                end
                default: begin
                    state_r <= S_REQ;
                    kill_r  <= 1'b0;
                end
            endcase
        end
    end

    // Request valid comes from state only; rst masks it during the reset cycle.
    assign imem_req_valid = (state_r == S_REQ) && !rst;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = (state_r == S_HOLD);
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign opcode         = inst_r[6:0];

endmodule
